// File: rtl/memory_round_ctrl.sv
// Round engine for the memory tester: builds an LFSR symbol sequence, plays it
// to the display, checks the player's keys and reports win/lose.
module memory_round_ctrl #(
    parameter int          SYM_W       = 2,
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYC    = 8,
    parameter int          GAP_CYC     = 2,
    parameter int          TIMEOUT_CYC = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             auth_bit,
    input  logic             log_out,
    input  logic             rng_button,
    input  logic [3:0]       level_num,
    input  logic             key_valid,
    input  logic [SYM_W-1:0] key_sym,
    output logic             disp_valid,
    output logic [SYM_W-1:0] disp_sym,
    output logic             win,
    output logic             lose,
    output logic             busy,
    output logic [4:0]       round_len
);

    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > SHOW_CYC) ?
                             ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                             ((SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        SHOW    = 3'd2,
        GAP     = 3'd3,
        WAIT_IN = 3'd4,
        WIN     = 3'd5,
        LOSE    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         len_q, len_d;
    logic [15:0]        lfsr_q;
    logic [SYM_W-1:0]   seq_q [MAX_LEN];

    logic               disp_valid_q, disp_valid_d;
    logic [SYM_W-1:0]   disp_sym_q, disp_sym_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               busy_q, busy_d;

    logic [4:0]         lvl_plus_s;
    logic [4:0]         len_new_s;
    logic               last_s;
    logic               abort_s;
    logic               gen_we_s;
    logic [SYM_W-1:0]   lfsr_sym_s;

    assign lvl_plus_s = {1'b0, level_num} + 5'd1;
    assign len_new_s  = (lvl_plus_s > 5'(MAX_LEN)) ? 5'(MAX_LEN) : lvl_plus_s;
    assign last_s     = (5'(idx_q) == (len_q - 5'd1));
    assign abort_s    = (!auth_bit) || log_out;
    assign gen_we_s   = (state_q == GEN);
    assign lfsr_sym_s = lfsr_q[SYM_W-1:0];

    // Next-state, index and counter logic; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if ((state_q != IDLE) && abort_s) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rng_button && auth_bit && !log_out) begin
                        state_d = GEN;
                        len_d   = len_new_s;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                GEN: begin
                    if (last_s) begin
                        state_d = SHOW;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(SHOW_CYC - 1)) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        cnt_d = '0;
                        if (last_s) begin
                            state_d = WAIT_IN;
                            idx_d   = '0;
                        end else begin
                            state_d = SHOW;
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IN: begin
                    // Timeout counter restarts on every correct key.
                    if (key_valid) begin
                        if (key_sym != seq_q[idx_q]) begin
                            state_d = LOSE;
                        end else if (last_s) begin
                            state_d = WIN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            cnt_d = '0;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                        state_d = LOSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WIN, LOSE: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        disp_valid_d = (state_d == SHOW);
        win_d        = (state_d == WIN);
        lose_d       = (state_d == LOSE);
        busy_d       = (state_d != IDLE);
        // Forward the symbol being written when a 1-long sequence enters SHOW.
        if (!disp_valid_d) begin
            disp_sym_d = '0;
        end else if (gen_we_s && (idx_d == idx_q)) begin
            disp_sym_d = lfsr_sym_s;
        end else begin
            disp_sym_d = seq_q[idx_d];
        end
    end

    // Control state, LFSR and registered outputs.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            len_q        <= 5'd0;
            lfsr_q       <= LFSR_SEED;
            disp_valid_q <= 1'b0;
            disp_sym_q   <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            disp_valid_q <= disp_valid_d;
            disp_sym_q   <= disp_sym_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            busy_q       <= busy_d;
        end
    end

    // Sequence storage; contents are irrelevant outside a round, so no reset.
    always_ff @(posedge clock) begin
        if (gen_we_s) begin
            seq_q[idx_q] <= lfsr_sym_s;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_sym   = disp_sym_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign busy       = busy_q;
    assign round_len  = len_q;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Directed + randomized bench for memory_round_ctrl; expected symbols come from
// an LFSR model indexed by the number of clock edges since reset.
module tb_memory_round_ctrl;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       auth_bit = 1'b0;
    logic       log_out = 1'b0;
    logic       rng_button = 1'b0;
    logic [3:0] level_num = 4'd0;
    logic       key_valid = 1'b0;
    logic [1:0] key_sym = 2'd0;

    logic       disp_valid, win, lose, busy;
    logic [1:0] disp_sym;
    logic [4:0] round_len;

    logic       disp_valid8, win8, lose8, busy8;
    logic [1:0] disp_sym8;
    logic [4:0] round_len8;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    memory_round_ctrl dut (
        .clock(clock), .rst(rst), .auth_bit(auth_bit), .log_out(log_out),
        .rng_button(rng_button), .level_num(level_num), .key_valid(key_valid),
        .key_sym(key_sym), .disp_valid(disp_valid), .disp_sym(disp_sym),
        .win(win), .lose(lose), .busy(busy), .round_len(round_len)
    );

    memory_round_ctrl #(.MAX_LEN(8)) dut8 (
        .clock(clock), .rst(rst), .auth_bit(auth_bit), .log_out(log_out),
        .rng_button(rng_button), .level_num(level_num), .key_valid(key_valid),
        .key_sym(key_sym), .disp_valid(disp_valid8), .disp_sym(disp_sym8),
        .win(win8), .lose(lose8), .busy(busy8), .round_len(round_len8)
    );

    always #5 clock = ~clock;

    // Edges since the last reset release; the DUT's LFSR has stepped this many times.
    always @(posedge clock or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_n(input int n);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 16'd0);
        chk({tag, "_disp"}, disp_valid, 16'd0);
        chk({tag, "_win"}, win, 16'd0);
        chk({tag, "_lose"}, lose, 16'd0);
    endtask

    // mode: 0 play, 2 timeout, 3 log_out in SHOW, 4 auth drop on final key.
    task automatic run_round(input int lvl, input int mode, input int wrong_at,
                             input int gap, input bit hold);
        int len;
        int ks;
        int g;
        logic [15:0] t;
        logic [1:0]  exp[$];
        len = (lvl + 1 > 16) ? 16 : lvl + 1;
        level_num  = 4'(lvl);
        rng_button = 1'b1;
        ks = cyc + 1;
        tick;
        if (!hold) rng_button = 1'b0;
        chk("busy_start", busy, 16'd1);
        chk("round_len", round_len, 16'(len));
        for (int i = 0; i < len; i++) begin
            t = lfsr_n(ks + i);
            exp.push_back(t[1:0]);
        end
        // Stray key and level change during GEN must both be ignored.
        level_num = 4'($urandom);
        key_valid = 1'b1;
        key_sym   = exp[0] + 2'd1;
        for (int i = 0; i < len; i++) begin
            chk("gen_disp", disp_valid, 16'd0);
            chk("gen_pulse", {win, lose}, 16'd0);
            tick;
            key_valid = 1'b0;
        end
        chk("round_len_held", round_len, 16'(len));
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < 8; c++) begin
                chk("show_valid", disp_valid, 16'd1);
                chk("show_sym", disp_sym, 16'(exp[i]));
                if (mode == 3 && i == 0 && c == 3) begin
                    log_out = 1'b1;
                    tick;
                    log_out = 1'b0;
                    chk_quiet("logout");
                    return;
                end
                tick;
            end
            for (int c = 0; c < 2; c++) begin
                chk("gap_valid", disp_valid, 16'd0);
                chk("gap_sym", disp_sym, 16'd0);
                tick;
            end
        end
        if (mode == 2) begin
            for (int c = 0; c <= 64; c++) begin
                chk("to_wait_lose", lose, 16'd0);
                chk("to_wait_busy", busy, 16'd1);
                tick;
            end
            chk("to_lose", lose, 16'd1);
            chk("to_win", win, 16'd0);
            tick;
            chk_quiet("to_after");
            return;
        end
        for (int i = 0; i < len; i++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            for (int c = 0; c < g; c++) begin
                chk("wait_pulse", {win, lose}, 16'd0);
                tick;
            end
            key_valid = 1'b1;
            key_sym   = (i == wrong_at) ? (exp[i] ^ 2'd2) : exp[i];
            if (mode == 4 && i == len - 1) auth_bit = 1'b0;
            tick;
            key_valid = 1'b0;
            if (mode == 4 && i == len - 1) begin
                chk_quiet("auth_abort");
                auth_bit = 1'b1;
                return;
            end
            if (i == wrong_at) begin
                chk("wrong_lose", lose, 16'd1);
                chk("wrong_win", win, 16'd0);
                chk("wrong_busy", busy, 16'd1);
                tick;
                chk_quiet("wrong_after");
                return;
            end
            if (i == len - 1) begin
                chk("win_pulse", win, 16'd1);
                chk("win_lose", lose, 16'd0);
                chk("win_busy", busy, 16'd1);
                tick;
                chk_quiet("win_after");
            end else begin
                chk("key_ok_pulse", {win, lose}, 16'd0);
                chk("key_ok_busy", busy, 16'd1);
            end
        end
    endtask

    initial begin
        int lvl;
        #12;
        chk_quiet("reset");
        chk("reset_len", round_len, 16'd0);
        chk("reset_lfsr", dut.lfsr_q, 16'hACE1);
        auth_bit = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        chk_quiet("idle");

        run_round(15, 0, -1, -1, 1'b0);
        chk("round_len_max8", round_len8, 16'd8);
        run_round(0, 0, -1, -1, 1'b0);
        run_round(3, 0, -1, -1, 1'b0);
        run_round(2, 0, 1, -1, 1'b0);
        run_round(1, 2, -1, -1, 1'b0);
        run_round(2, 0, -1, 60, 1'b0);
        run_round(1, 3, -1, -1, 1'b0);
        run_round(0, 4, -1, -1, 1'b0);
        repeat (6) begin
            lvl = int'($urandom_range(0, 15));
            run_round(lvl, 0, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, lvl)),
                      -1, 1'b0);
        end
        run_round(1, 0, -1, -1, 1'b1);
        run_round(2, 0, -1, -1, 1'b1);
        run_round(0, 0, -1, -1, 1'b0);

        // Reset in the middle of GEN.
        level_num  = 4'd15;
        rng_button = 1'b1;
        tick;
        rng_button = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk_quiet("midrst");
        chk("midrst_len", round_len, 16'd0);
        chk("midrst_lfsr", dut.lfsr_q, 16'hACE1);
        tick;
        rst = 1'b1;
        tick;
        chk_quiet("midrst_idle");
        run_round(4, 0, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
